alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencing controller for the arithmetic unit. It accepts one operation at a time through a start/busy/done handshake and completes add and sub in a single pass. It implements mul (shift-add) and div (restoring) iteratively over `width` cycles using one shared add/sub stage. Results and overflow are registered and held for the consumer. It sits between the top-level operand/function source and the result display/status logic.

## Interface
- `width`, default 6: operand width in bits; result is `2*width` bits.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `start`  input  1  request pulse/level; accepted only on an edge where `busy`=0.
- `a`  input  `width`  operand A, unsigned; sampled at acceptance only.
- `b`  input  `width`  operand B, unsigned; sampled at acceptance only.
- `func`  input  2  op select, sampled at acceptance: 00 add, 01 sub, 10 mul, 11 div.
- `busy`  output  1  high while an iterative op is in progress.
- `done`  output  1  one-cycle pulse when `out`/`overflow` are updated.
- `out`  output  `2*width`  registered result, held until the next completion.
- `overflow`  output  1  registered status for the result in `out`.

## Operation
- States: IDLE, CALC, DONE. `busy` = (state == CALC). `done` = (state == DONE).
- Acceptance: rising edge with `rst_n`=1, `start`=1 and state IDLE or DONE. At acceptance, `a`, `b` and `func` are latched internally. Later input changes have no effect on the operation in flight.
- add: `out` = zero-extended `a+b` (`width+1` bits). `overflow` = carry out of bit `width-1`, i.e. `out[width]`. Next state DONE.
- sub: `out` = zero-extended `(a-b) mod 2^width`, upper `width` bits 0. `overflow` = borrow (`a<b`). Next state DONE.
- div with `b`=0: no iteration. `out` = {`a`, all ones}. `overflow`=1. Next state DONE.
- mul: next state CALC, iteration counter = `width`. Each CALC cycle examines multiplier LSB, conditionally adds multiplicand into the `2*width` accumulator upper half, then shifts right one bit. After `width` iterations `out` = full product, `overflow`=0, next state DONE.
- div (`b`≠0): next state CALC, counter = `width`. Each cycle uses a restoring step: shift {remainder, dividend} left 1, trial-subtract `b` from the `width+1`-bit remainder, keep it if non-negative, and set the quotient bit. After `width` iterations `out` = {remainder, quotient} (upper `width` = remainder, lower `width` = quotient), `overflow`=0, next state DONE.
- DONE: `out`/`overflow` were loaded on entry. If `start`=1, a new op is accepted (back-to-back). Otherwise go to IDLE.
- `start` in CALC: ignored, not queued.
- `out`/`overflow` change only on the edge entering DONE. The intermediate accumulator is internal and never visible on `out`.

## Timing
- Reset (edge with `rst_n`=0, from any state including mid-CALC): state IDLE, `busy`=0, `done`=0, `out`=0, `overflow`=0, counter=0. Any in-flight op is discarded with no `done`.
- Cycle 0 is the acceptance edge.
- add/sub/div-by-zero: `done`=1 during cycle 1. `busy` never asserts. Latency 1.
- mul/div: `busy`=1 during cycles 1..`width`. `done`=1 during cycle `width+1`. Latency `width+1` (7 for `width`=6).
- Back-to-back: `start` during a DONE cycle gives acceptance on that edge. The next `done` follows at the same latencies. Maximum throughput is one add/sub per cycle.
- `done` is never high for two consecutive cycles unless two ops were accepted back-to-back.

## Test plan
- Reset, then add `a`=63, `b`=1 (`width`=6): `done` in cycle 1, `out`=64 (0x040), `overflow`=1, `busy` stays 0.
- sub `a`=5, `b`=9: `done` in cycle 1, `out`=60 (0x03C), `overflow`=1. Then sub 9−5: `out`=4, `overflow`=0.
- mul `a`=63, `b`=63: `busy` high exactly 6 cycles, `done` in cycle 7, `out`=3969 (0xF81), `overflow`=0. Toggling `a`/`b`/`start` during `busy` changes nothing.
- div `a`=45, `b`=7: `done` in cycle 7, `out`=198 (0x0C6: remainder 3, quotient 6). div `a`=13, `b`=0: `done` in cycle 1, `out`=895 (0x37F), `overflow`=1.
- Back-to-back: add 2+3 with `start` held into its DONE cycle for mul 5×5. Required: `out`=5 at cycle 1, then `out`=25 at cycle 8.
- Reset mid-mul: `rst_n`=0 at cycle 3. Next cycle `busy`=0, `out`=0, `overflow`=0, and no `done` pulse follows.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Operand/result bundle between the operand source and alu_seq_ctrl.
//   start    : request; taken only when the controller is not busy
//   a, b     : unsigned operands, sampled on acceptance
//   func     : 00 add, 01 sub, 10 mul, 11 div
//   busy     : iterative operation in progress
//   done     : one-cycle pulse when out/overflow update
//   out      : 2*width result, held until the next completion
//   overflow : status belonging to the value in out
interface alu_seq_ctrl_if #(
  parameter int unsigned width = 6
) ();
  logic                 start;
  logic [width-1:0]     a;
  logic [width-1:0]     b;
  logic [1:0]           func;
  logic                 busy;
  logic                 done;
  logic [2*width-1:0]   out;
  logic                 overflow;

  modport master (
    output start, a, b, func,
    input  busy, done, out, overflow
  );

  modport slave (
    input  start, a, b, func,
    output busy, done, out, overflow
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the arithmetic unit.
// add/sub and divide-by-zero complete on the acceptance edge; mul (shift-add) and
// div (restoring) iterate for width cycles through one shared add/sub stage.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_seq_ctrl_if slave (start/a/b/func in, busy/done/out/overflow out)
module alu_seq_ctrl #(
  parameter int unsigned width = 6
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(width + 1);
  localparam int unsigned SumW = width + 2;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
  typedef enum logic [1:0] {FnAdd = 2'b00, FnSub = 2'b01, FnMul = 2'b10, FnDiv = 2'b11} func_e;

  state_e               state_q;
  func_e                op_q;
  logic [width-1:0]     b_q;
  logic [2*width-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*width-1:0]   out_q;
  logic                 ovf_q;

  func_e                func_in;
  logic [width:0]       rem_sh;
  logic [SumW-1:0]      op_x;
  logic [SumW-1:0]      op_y;
  logic                 op_sub;
  logic [SumW-1:0]      sum;
  logic [2*width-1:0]   acc_next;

  assign func_in = func_e'(bus.func);

  // Shared add/sub stage. Outside CALC it serves the single-pass add/sub on the raw
  // inputs; inside CALC it is the mul accumulate or the div trial subtraction.
  // Two spare top bits make the sign of any subtraction visible in sum[width+1].
  always_comb begin
    rem_sh = {acc_q[2*width-1:width], acc_q[width-1]};
    op_x   = '0;
    op_y   = '0;
    op_sub = 1'b0;
    if (state_q == StCalc) begin
      op_y = SumW'(b_q);
      if (op_q == FnMul) begin
        op_x   = SumW'(acc_q[2*width-1:width]);
        op_sub = 1'b0;
      end else begin
        op_x   = SumW'(rem_sh);
        op_sub = 1'b1;
      end
    end else begin
      op_x   = SumW'(bus.a);
      op_y   = SumW'(bus.b);
      op_sub = (func_in == FnSub);
    end
    sum = op_x + (op_sub ? ~op_y : op_y) + SumW'(op_sub);
  end

  // One iteration step. mul: acc = {partial product, remaining multiplier bits}.
  // div: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  always_comb begin
    acc_next = acc_q;
    if (op_q == FnMul) begin
      if (acc_q[0]) begin
        acc_next = {sum[width:0], acc_q[width-1:1]};
      end else begin
        acc_next = {1'b0, acc_q[2*width-1:1]};
      end
    end else begin
      if (sum[width+1]) begin
        // Trial went negative: restore the shifted remainder, quotient bit 0.
        acc_next = {rem_sh[width-1:0], acc_q[width-2:0], 1'b0};
      end else begin
        acc_next = {sum[width-1:0], acc_q[width-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= FnAdd;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (bus.start) begin
            op_q <= func_in;
            b_q  <= bus.b;
            unique case (func_in)
              FnAdd: begin
                out_q   <= {{(width-1){1'b0}}, sum[width:0]};
                ovf_q   <= sum[width];
                done_q  <= 1'b1;
                state_q <= StDone;
              end
              FnSub: begin
                out_q   <= {{width{1'b0}}, sum[width-1:0]};
                ovf_q   <= sum[width+1];
                done_q  <= 1'b1;
                state_q <= StDone;
              end
              FnMul: begin
                acc_q   <= {{width{1'b0}}, bus.a};
                cnt_q   <= CntW'(width);
                busy_q  <= 1'b1;
                state_q <= StCalc;
              end
              FnDiv: begin
                if (bus.b == '0) begin
                  out_q   <= {bus.a, {width{1'b1}}};
                  ovf_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= StDone;
                end else begin
                  acc_q   <= {{width{1'b0}}, bus.a};
                  cnt_q   <= CntW'(width);
                  busy_q  <= 1'b1;
                  state_q <= StCalc;
                end
              end
              default: state_q <= StIdle;
            endcase
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            out_q   <= acc_next;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out      = out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed operations with literal expectations plus a
// per-cycle comparison against a latency/arithmetic model.
module tb_alu_seq_ctrl;
  localparam int W = 6;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_ctrl_if #(.width(W)) bus ();

  alu_seq_ctrl #(.width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: pending result and the number of edges left until it appears.
  int          m_rem  = 0;
  logic [11:0] m_out  = '0;
  logic        m_ovf  = 1'b0;
  logic        m_done = 1'b0;
  logic [11:0] m_pend = '0;
  logic        m_pend_ovf = 1'b0;
  bit          chk_en = 1'b0;

  function automatic void compute(input int fa, input int fb, input int fn,
                                  output logic [11:0] r, output logic v, output int lat);
    r = '0; v = 1'b0; lat = 0;
    case (fn)
      0: begin r = 12'(fa + fb); v = (fa + fb) >= M; lat = 0; end
      1: begin r = 12'((fa - fb + M) % M); v = fa < fb; lat = 0; end
      2: begin r = 12'(fa * fb); v = 1'b0; lat = W; end
      default: begin
        if (fb == 0) begin r = 12'(fa * M + (M - 1)); v = 1'b1; lat = 0; end
        else begin r = 12'((fa % fb) * M + fa / fb); v = 1'b0; lat = W; end
      end
    endcase
  endfunction

  task automatic model_step();
    logic [11:0] r;
    logic        v;
    int          lat;
    bit          free;
    if (!rst_n) begin
      m_rem = 0; m_out = '0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      free   = (m_rem == 0);
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_out = m_pend; m_ovf = m_pend_ovf; m_done = 1'b1;
        end
      end
      if (free && bus.start) begin
        compute(int'(bus.a), int'(bus.b), int'(bus.func), r, v, lat);
        if (lat == 0) begin
          m_out = r; m_ovf = v; m_done = 1'b1;
        end else begin
          m_rem = lat; m_pend = r; m_pend_ovf = v;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_busy", 32'(bus.busy), 32'(m_rem > 0));
      chk("cyc_done", 32'(bus.done), 32'(m_done));
      chk("cyc_out",  32'(bus.out),  32'(m_out));
      chk("cyc_ovf",  32'(bus.overflow), 32'(m_ovf));
    end
  end

  task automatic run_op(input int ta, input int tb_, input int tf, input int exp_lat,
                        input logic [11:0] exp_o, input logic exp_v, input string nm);
    int n;
    @(negedge clk);
    bus.a = 6'(ta); bus.b = 6'(tb_); bus.func = 2'(tf); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"},   32'(n), 32'(exp_lat));
    chk({nm, "_out"},   32'(bus.out), 32'(exp_o));
    chk({nm, "_ovf"},   32'(bus.overflow), 32'(exp_v));
    chk({nm, "_model"}, 32'(m_out), 32'(exp_o));
  endtask

  initial begin
    int n;
    int busy_cnt;
    bit seen;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.func = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out",  32'(bus.out), 32'd0);
    chk("rst_ovf",  32'(bus.overflow), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    run_op(63, 1, 0, 1, 12'h040, 1'b1, "add63_1");
    run_op(5,  9, 1, 1, 12'h03C, 1'b1, "sub5_9");
    run_op(9,  5, 1, 1, 12'h004, 1'b0, "sub9_5");
    run_op(20, 22, 0, 1, 12'h02A, 1'b0, "add20_22");

    // mul 63*63 with inputs and start scrambled while busy
    @(negedge clk);
    bus.a = 6'd63; bus.b = 6'd63; bus.func = 2'd2; bus.start = 1'b1;
    busy_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (i < 6) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = 6'($urandom_range(0, 63));
        bus.b     = 6'($urandom_range(0, 63));
        bus.func  = 2'($urandom_range(0, 3));
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("mul63_busycnt", 32'(busy_cnt), 32'd6);
    chk("mul63_done", 32'(bus.done), 32'd1);
    chk("mul63_out",  32'(bus.out), 32'd3969);
    chk("mul63_ovf",  32'(bus.overflow), 32'd0);

    run_op(45, 7, 3, 7, 12'h0C6, 1'b0, "div45_7");
    run_op(13, 0, 3, 1, 12'h37F, 1'b1, "div13_0");
    run_op(5,  9, 3, 7, 12'd320, 1'b0, "div5_9");
    run_op(63, 1, 3, 7, 12'd63,  1'b0, "div63_1");
    run_op(1, 63, 2, 7, 12'd63,  1'b0, "mul1_63");

    // back-to-back: add 2+3 then mul 5*5 accepted in the add's DONE cycle
    @(negedge clk);
    bus.a = 6'd2; bus.b = 6'd3; bus.func = 2'd0; bus.start = 1'b1;
    @(negedge clk);
    chk("b2b_add_done", 32'(bus.done), 32'd1);
    chk("b2b_add_out",  32'(bus.out), 32'd5);
    bus.a = 6'd5; bus.b = 6'd5; bus.func = 2'd2;
    @(negedge clk);
    bus.start = 1'b0;
    n = 2;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_mul_cycle", 32'(n), 32'd8);
    chk("b2b_mul_out",   32'(bus.out), 32'd25);

    // reset in the middle of a multiply
    @(negedge clk);
    bus.a = 6'd7; bus.b = 6'd9; bus.func = 2'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_out",  32'(bus.out), 32'd0);
    chk("midrst_ovf",  32'(bus.overflow), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
